// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run_ctrl harness block.
// Halt detection is built in only when RUN_CTRL_HALT_DET_EN is defined.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int DEF_PC_W        = 32;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_RST_HOLD    = 1;
  localparam int DEF_MAX_CYCLES  = 100000;
  localparam int DEF_HALT_REPEAT = 4;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    if (n < 2) begin
      return 1;
    end else begin
      return $clog2(n + 1);
    end
  endfunction

endpackage

// File: rtl/run_ctrl_halt_detector.sv
// Counts consecutive identical valid PC samples while enabled; hit marks the
// sample that completes HALT_REPEAT repeats, so the parent can capture pc with it.
module halt_detector
  import run_ctrl_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [PC_W-1:0] pc,
  input  logic            pc_valid,
  output logic            hit
);

  localparam int REP_W = cnt_width(HALT_REPEAT);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(HALT_REPEAT);

  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_d;
  logic [PC_W-1:0]  last_q;
  logic             sample_s;

  assign sample_s = enable & pc_valid;

  // A zero repeat count doubles as "no sample taken yet".
  always_comb begin
    rep_d = rep_q;
    if (sample_s) begin
      if ((rep_q != '0) && (pc == last_q)) begin
        if (rep_q != REP_MAX) begin
          rep_d = rep_q + REP_W'(1);
        end else begin
          rep_d = rep_q;
        end
      end else begin
        rep_d = REP_W'(1);
      end
    end else begin
      rep_d = rep_q;
    end
  end

  assign hit = sample_s & (rep_d == REP_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q  <= '0;
      last_q <= '0;
    end else if (sample_s) begin
      rep_q  <= rep_d;
      last_q <= pc;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run control for the CPU harness: holds core reset, counts RUN cycles, ends on
// timeout or (with RUN_CTRL_HALT_DET_EN defined) on a PC self-loop halt.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RST_HOLD    = DEF_RST_HOLD,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [PC_W-1:0]  halt_pc
);

  localparam int HOLD_W = cnt_width(RST_HOLD);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   halt_pc_q, halt_pc_d;
  logic              hit_s;

`ifdef RUN_CTRL_HALT_DET_EN
  halt_detector #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt_detector (
    .clk      (clk),
    .reset    (reset),
    .enable   (state_q == ST_RUN),
    .pc       (pc),
    .pc_valid (pc_valid),
    .hit      (hit_s)
  );
`else
  logic unused_pc_s;
  assign unused_pc_s = ^{pc_valid, pc};
  assign hit_s       = 1'b0;
`endif

  // Next-state logic; halt beats timeout when both land on the same edge.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    halt_pc_d = halt_pc_q;
    case (state_q)
      ST_HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_d == HOLD_W'(RST_HOLD)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (hit_s) begin
          state_d   = ST_HALTED;
          halt_pc_d = pc;
        end else if (cnt_d == CNT_W'(MAX_CYCLES)) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED:  state_d = ST_HALTED;
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_HOLD;
      hold_q    <= '0;
      cnt_q     <= '0;
      halt_pc_q <= '0;
      cpu_reset <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      halted    <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      halt_pc_q <= halt_pc_d;
      cpu_reset <= (state_d != ST_RUN);
      running   <= (state_d == ST_RUN);
      done      <= (state_d == ST_HALTED) || (state_d == ST_TIMEOUT);
      halted    <= (state_d == ST_HALTED);
      timed_out <= (state_d == ST_TIMEOUT);
    end
  end

  assign cycle_cnt = cnt_q;
  assign halt_pc   = halt_pc_q;

endmodule
